// File: rtl/encoder_8to3_filt_if.sv
// rtl/encoder_8to3_filt_if.sv - one-hot word in, filtered 3-bit code and error status out
interface encoder_8to3_filt_if #(
   parameter int ERR_W = 8
);
   logic [7:0]       in;
   logic             err_clr;
   logic             out1;
   logic             out2;
   logic             out3;
   logic             code_vld;
   logic             err;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output in, err_clr,
      input  out1, out2, out3, code_vld, err, err_cnt
   );

   modport slave (
      input  in, err_clr,
      output out1, out2, out3, code_vld, err, err_cnt
   );
endinterface

// File: rtl/encoder_8to3_filt.sv
// rtl/encoder_8to3_filt.sv - stability-filtered registered 8-to-3 one-hot encoder
module encoder_8to3_filt #(
   parameter int STABLE_CNT = 4,
   parameter int ERR_W      = 8
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   encoder_8to3_filt_if.slave  bus
);
   localparam int CNT_W = $clog2(STABLE_CNT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

   typedef enum logic [1:0] {IDLE, FILTER, DONE} state_t;

   state_t           state;
   logic [7:0]       in_d;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       code;
   logic             code_vld;
   logic             err;
   logic [ERR_W-1:0] err_cnt;

   logic       change;
   logic       eval;
   logic [3:0] hot_cnt;
   logic [2:0] hot_idx;

   assign change = (bus.in != in_d);
   // The word has sat unchanged in in_d for STABLE_CNT edges after capture
   assign eval   = (state == FILTER) && !change && (cnt == LAST);

   always_comb begin
      hot_cnt = '0;
      hot_idx = '0;
      for (int k = 0; k < 8; k++) begin
         if (in_d[k]) begin
            hot_cnt = hot_cnt + 4'd1;
            hot_idx = 3'(k);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         in_d     <= '0;
         cnt      <= '0;
         code     <= '0;
         code_vld <= 1'b0;
         err      <= 1'b0;
         err_cnt  <= '0;
      end else begin
         in_d     <= bus.in;
         code_vld <= 1'b0;
         err      <= 1'b0;

         case (state)
            IDLE: begin
               if (change) begin
                  state <= FILTER;
                  cnt   <= '0;
               end
            end
            FILTER: begin
               if (change)
                  cnt <= '0;
               else if (cnt == LAST)
                  state <= DONE;
               else
                  cnt <= cnt + CNT_W'(1);
            end
            DONE: begin
               if (change) begin
                  state <= FILTER;
                  cnt   <= '0;
               end
            end
            default: state <= IDLE;
         endcase

         // An all-zero word is an idle line: neither reported nor an error
         if (eval && hot_cnt == 4'd1) begin
            code     <= hot_idx;
            code_vld <= 1'b1;
         end
         if (eval && hot_cnt > 4'd1)
            err <= 1'b1;

         if (bus.err_clr)
            err_cnt <= '0;
         else if (eval && hot_cnt > 4'd1 && err_cnt != '1)
            err_cnt <= err_cnt + ERR_W'(1);
      end
   end

   assign bus.out1     = code[2];
   assign bus.out2     = code[1];
   assign bus.out3     = code[0];
   assign bus.code_vld = code_vld;
   assign bus.err      = err;
   assign bus.err_cnt  = err_cnt;
endmodule
